lvg_sequencer: RTL and testbench
================================

Name: lvg_sequencer

Overview:
Instruction sequencer for the lvg matrix engine. It accepts 16-bit instructions over a valid/ready handshake. It decodes load and matmul opcodes and generates every control strobe and row counter the drippers, systolic array, dispatcher, relu stage and aggregator need. This replaces the ad-hoc control logic at the top of lvg: the datapath only consumes this block's registered outputs.

Parameters:
DIM, 4, systolic array dimension (rows per dispatch/aggregate phase)
CNT_W, 6, width of all count outputs
SYS_CYCLES, 11, feed cycles per matmul (3*DIM-1); must be below 2^CNT_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept an instruction
instr  in  16  [7:0] opcode, [15:8] addr/flags
load_l  out  1  one-cycle load pulse to left dripper
load_r  out  1  one-cycle load pulse to right dripper
srst  out  1  systolic array accumulator clear
sys_count  out  CNT_W  dripper/feed step, 0 when not feeding
dis_count  out  CNT_W  dispatcher row select, 0 when idle
agg_count  out  CNT_W  aggregator row, non-activated path
agg_act_count  out  CNT_W  aggregator row, relu path
should_add  out  1  dispatcher adds bias matrix
should_act  out  1  relu stage enable
busy  out  1  matmul in progress
done  out  1  one-cycle matmul completion pulse
err  out  1  one-cycle illegal-opcode pulse

Behaviour:
- Reset (async, any state): state IDLE. All outputs 0 except instr_ready=1. Latched flags cleared. A matmul in flight is abandoned with no done pulse.
- All outputs are registered. Accept = instr_valid && instr_ready at a rising edge (cycle T).
- instr_ready=1 only in IDLE. Held 0 from T+1 of a matmul until the state returns to IDLE.
- Opcode 0 NOP: accepted, no effect.
- Opcode 1 LOADL: load_l=1 during T+1 only. Stays IDLE, so back-to-back loads are legal every cycle.
- Opcode 2 LOADR: same as LOADL, driving load_r.
- Opcode 3 MATMUL: latch add=addr[0] and act=addr[1]. Then:
  - SRST, T+1: srst=1, busy=1, sys_count=0.
  - FEED, T+2..T+1+SYS_CYCLES: srst=0, sys_count=1..SYS_CYCLES, incrementing by 1 each cycle.
  - DISP, next DIM cycles: sys_count=0, dis_count=1..DIM, should_add=add, should_act=act.
  - TAIL: 1 cycle if act=0, 2 cycles if act=1.
  - Aggregator timing: if act=0, agg_count = dis_count delayed 1 cycle and agg_act_count=0. If act=1, agg_act_count = dis_count delayed 2 cycles and agg_count=0.
  - DONE: the cycle after the last nonzero aggregator count. done=1, busy=0, state IDLE, instr_ready=1.
  - Total length (DIM=4, SYS_CYCLES=11): act=0 gives done at T+18; act=1 gives done at T+19.
- Any other opcode: accepted, err=1 during T+1, no other effect.
- addr bits [7:2] are ignored.
- Counters never wrap: each counter is forced back to 0 outside its phase.
- instr_valid arriving while busy: no accept and no side effects. The instruction is held by the source.

Test Plan:
- Assert rst mid-FEED at sys_count=6 -> next edge all outputs 0, instr_ready=1; no done pulse; next instruction accepted normally.
- LOADL at T, LOADR at T+1 -> load_l high only at T+1, load_r high only at T+2; instr_ready stays 1 throughout.
- MATMUL addr=0x00 at T -> srst=1 at T+1; sys_count 1..11 over T+2..T+12; dis_count 1..4 over T+13..T+16 with should_add=should_act=0; agg_count 1..4 over T+14..T+17; done=1 at T+18.
- MATMUL addr=0x03 -> should_add=should_act=1 over T+13..T+16; agg_act_count 1..4 over T+15..T+18; agg_count stays 0; done at T+19.
- LOADL held valid during a MATMUL -> not accepted until the done cycle; load_l pulses exactly once, the cycle after acceptance.
- Opcode 0x7F -> err=1 for one cycle; all other outputs unchanged; instr_ready=1.

Source files
------------

// File: rtl/lvg_sequencer.sv
// Instruction sequencer for the lvg matrix engine: decodes load/matmul opcodes
// and produces registered control strobes and row counters for the datapath.
module lvg_sequencer #(
    parameter int DIM        = 4,
    parameter int CNT_W      = 6,
    parameter int SYS_CYCLES = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic             load_l,
    output logic             load_r,
    output logic             srst,
    output logic [CNT_W-1:0] sys_count,
    output logic [CNT_W-1:0] dis_count,
    output logic [CNT_W-1:0] agg_count,
    output logic [CNT_W-1:0] agg_act_count,
    output logic             should_add,
    output logic             should_act,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, SRST, FEED, DISP, TAIL} state_t;

    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_CYCLES);
    localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DIM);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           r_state, w_state;
    logic             r_add, w_add, r_act, w_act, r_tail, w_tail;
    logic [CNT_W-1:0] r_dis_d1, w_dis_d1;
    logic             r_ready, w_ready, r_ll, w_ll, r_lr, w_lr, r_srst, w_srst;
    logic [CNT_W-1:0] r_sys, w_sys, r_dis, w_dis, r_agg, w_agg, r_agg_act, w_agg_act;
    logic             r_sadd, w_sadd, r_sact, w_sact, r_busy, w_busy;
    logic             r_done, w_done, r_err, w_err;
    logic             w_unused;

    assign w_unused = ^instr[15:10];

    always_comb begin
        w_state   = r_state;
        w_add     = r_add;
        w_act     = r_act;
        w_tail    = 1'b0;
        w_ll      = 1'b0;
        w_lr      = 1'b0;
        w_srst    = 1'b0;
        w_err     = 1'b0;
        w_done    = 1'b0;
        w_sys     = '0;
        w_dis     = '0;
        w_sadd    = 1'b0;
        w_sact    = 1'b0;
        // Aggregator rows trail the dispatcher by one (plain) or two (relu) cycles.
        w_dis_d1  = r_dis;
        w_agg     = r_act ? '0 : r_dis;
        w_agg_act = r_act ? r_dis_d1 : '0;
        case (r_state)
            IDLE: begin
                if (instr_valid) begin
                    case (instr[7:0])
                        8'd0: ;
                        8'd1: w_ll = 1'b1;
                        8'd2: w_lr = 1'b1;
                        8'd3: begin
                            w_state = SRST;
                            w_srst  = 1'b1;
                            w_add   = instr[8];
                            w_act   = instr[9];
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            SRST: begin
                w_state = FEED;
                w_sys   = ONE;
            end
            FEED: begin
                if (r_sys == SYS_LAST) begin
                    w_state = DISP;
                    w_dis   = ONE;
                    w_sadd  = r_add;
                    w_sact  = r_act;
                end else begin
                    w_sys = r_sys + ONE;
                end
            end
            DISP: begin
                if (r_dis == DIS_LAST) begin
                    w_state = TAIL;
                end else begin
                    w_dis  = r_dis + ONE;
                    w_sadd = r_add;
                    w_sact = r_act;
                end
            end
            TAIL: begin
                if (!r_act || r_tail) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_tail = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
        w_ready = (w_state == IDLE);
        w_busy  = (w_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_add     <= 1'b0;
            r_act     <= 1'b0;
            r_tail    <= 1'b0;
            r_dis_d1  <= '0;
            r_ready   <= 1'b1;
            r_ll      <= 1'b0;
            r_lr      <= 1'b0;
            r_srst    <= 1'b0;
            r_sys     <= '0;
            r_dis     <= '0;
            r_agg     <= '0;
            r_agg_act <= '0;
            r_sadd    <= 1'b0;
            r_sact    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_add     <= w_add;
            r_act     <= w_act;
            r_tail    <= w_tail;
            r_dis_d1  <= w_dis_d1;
            r_ready   <= w_ready;
            r_ll      <= w_ll;
            r_lr      <= w_lr;
            r_srst    <= w_srst;
            r_sys     <= w_sys;
            r_dis     <= w_dis;
            r_agg     <= w_agg;
            r_agg_act <= w_agg_act;
            r_sadd    <= w_sadd;
            r_sact    <= w_sact;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    assign instr_ready   = r_ready;
    assign load_l        = r_ll;
    assign load_r        = r_lr;
    assign srst          = r_srst;
    assign sys_count     = r_sys;
    assign dis_count     = r_dis;
    assign agg_count     = r_agg;
    assign agg_act_count = r_agg_act;
    assign should_add    = r_sadd;
    assign should_act    = r_sact;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_lvg_sequencer.sv
// Directed self-checking bench for lvg_sequencer using immediate assertions.
module tb_lvg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        load_l, load_r, srst;
    logic [5:0]  sys_count, dis_count, agg_count, agg_act_count;
    logic        should_add, should_act, busy, done, err;

    int checks = 0;
    int errors = 0;

    lvg_sequencer #(.DIM(4), .CNT_W(6), .SYS_CYCLES(11)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .load_l(load_l), .load_r(load_r), .srst(srst),
        .sys_count(sys_count), .dis_count(dis_count), .agg_count(agg_count),
        .agg_act_count(agg_act_count), .should_add(should_add), .should_act(should_act),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_rdy, input int e_ll, input int e_lr,
                           input int e_srst, input int e_sys, input int e_dis, input int e_agg,
                           input int e_aa, input int e_add, input int e_act, input int e_busy,
                           input int e_done, input int e_err);
        chk({tag, ".ready"},   int'(instr_ready),   e_rdy);
        chk({tag, ".load_l"},  int'(load_l),        e_ll);
        chk({tag, ".load_r"},  int'(load_r),        e_lr);
        chk({tag, ".srst"},    int'(srst),          e_srst);
        chk({tag, ".sys"},     int'(sys_count),     e_sys);
        chk({tag, ".dis"},     int'(dis_count),     e_dis);
        chk({tag, ".agg"},     int'(agg_count),     e_agg);
        chk({tag, ".agg_act"}, int'(agg_act_count), e_aa);
        chk({tag, ".add"},     int'(should_add),    e_add);
        chk({tag, ".act"},     int'(should_act),    e_act);
        chk({tag, ".busy"},    int'(busy),          e_busy);
        chk({tag, ".done"},    int'(done),          e_done);
        chk({tag, ".err"},     int'(err),           e_err);
    endtask

    task automatic idle_chk(input string tag);
        chk_all(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Issues MATMUL at cycle T and checks cycles T+1 .. done; returns in the done cycle.
    // With hold set, a LOADL is held valid from T+1 onward.
    task automatic run_matmul(input string tag, input logic [7:0] addr, input bit hold);
        int a, d, last;
        int e_sys, e_dis, e_agg, e_aa, e_fl_add, e_fl_act;
        a = int'(addr[1]);
        d = int'(addr[0]);
        last = 18 + a;
        instr = {addr, 8'h03};
        instr_valid = 1'b1;
        step();
        instr_valid = hold;
        instr = hold ? 16'h0001 : 16'h0000;
        for (int k = 1; k <= last; k++) begin
            e_sys    = (k >= 2 && k <= 12) ? k - 1 : 0;
            e_dis    = (k >= 13 && k <= 16) ? k - 12 : 0;
            e_fl_add = (k >= 13 && k <= 16) ? d : 0;
            e_fl_act = (k >= 13 && k <= 16) ? a : 0;
            e_agg    = (a == 0 && k >= 14 && k <= 17) ? k - 13 : 0;
            e_aa     = (a == 1 && k >= 15 && k <= 18) ? k - 14 : 0;
            chk_all($sformatf("%s.T+%0d", tag, k), (k == last) ? 1 : 0, 0, 0,
                    (k == 1) ? 1 : 0, e_sys, e_dis, e_agg, e_aa, e_fl_add, e_fl_act,
                    (k < last) ? 1 : 0, (k == last) ? 1 : 0, 0);
            if (k < last) step();
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        #12;
        idle_chk("reset");
        rst = 1'b0;
        step();
        idle_chk("post_reset");

        // Back-to-back loads
        instr = 16'h0001; instr_valid = 1'b1;
        step();
        chk_all("loadl", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        instr = 16'h0002;
        step();
        chk_all("loadr", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        instr_valid = 1'b0;
        step();
        idle_chk("loads_end");

        // NOP and illegal opcode
        instr = 16'hFF00; instr_valid = 1'b1;
        step();
        idle_chk("nop");
        instr = 16'h007F;
        step();
        chk_all("err", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        instr_valid = 1'b0;
        step();
        idle_chk("err_end");

        // Plain matmul
        run_matmul("mm00", 8'h00, 1'b0);
        step();
        idle_chk("mm00_after");

        // Bias + relu matmul
        run_matmul("mm03", 8'h03, 1'b0);
        step();
        idle_chk("mm03_after");

        // Upper addr bits ignored: 0xFD -> add=1, act=0
        run_matmul("mmFD", 8'hFD, 1'b0);
        step();
        idle_chk("mmFD_after");

        // LOADL held during matmul, accepted at the done cycle
        run_matmul("hold", 8'h00, 1'b1);
        step();
        instr_valid = 1'b0;
        chk_all("hold_load", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        idle_chk("hold_end");

        // Reset mid-FEED at sys_count=6
        instr = 16'h0003; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int k = 2; k <= 7; k++) step();
        chk("rst_pre.sys", int'(sys_count), 6);
        chk("rst_pre.busy", int'(busy), 1);
        #2 rst = 1'b1;
        step();
        idle_chk("rst_mid");
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step();
            chk($sformatf("rst_nodone%0d", k), int'(done), 0);
            chk($sformatf("rst_ready%0d", k), int'(instr_ready), 1);
        end
        instr = 16'h0001; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk_all("rst_loadl", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        idle_chk("rst_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
